// File: rtl/link_recovery_ctrl_pkg.sv
// Shared state encoding, tune direction constants and counter widths for the
// link recovery sequencer.
package link_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MONITOR  = 3'd1,
    ST_TUNE_REQ = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_TRAIN    = 3'd4,
    ST_BACKOFF  = 3'd5,
    ST_FAILED   = 3'd6
  } state_t;

  localparam logic TUNE_HEAT = 1'b0;
  localparam logic TUNE_COOL = 1'b1;

  localparam int RETRY_W  = 4;
  localparam int MAG_W    = 4;
  localparam int REC_W    = 16;
  localparam int OUTAGE_W = 32;
  localparam int TIMER_W  = 32;

  // Timer load for a wait of (base << n) cycles; the timer counts down to zero inclusive.
  function automatic logic [TIMER_W-1:0] backoff_load(input logic [TIMER_W-1:0] base,
                                                      input logic [RETRY_W-1:0] n);
    return (base << n) - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/link_recovery_ctrl_if.sv
// Plant/monitor-facing signal bundle of the link recovery sequencer.
interface link_recovery_ctrl_if;
  import link_ctrl_pkg::*;

  logic                enable;
  logic                link_up;
  logic                tune_ack;
  logic                frame_valid;
  logic                tune_req;
  logic                tune_dir;
  logic [MAG_W-1:0]    tune_mag;
  logic [2:0]          state;
  logic [RETRY_W-1:0]  retry_cnt;
  logic [REC_W-1:0]    recoveries;
  logic [OUTAGE_W-1:0] outage_cycles;
  logic                failed;

  modport master (
    output enable, link_up, tune_ack,
    input  frame_valid, tune_req, tune_dir, tune_mag, state, retry_cnt,
           recoveries, outage_cycles, failed
  );

  modport slave (
    input  enable, link_up, tune_ack,
    output frame_valid, tune_req, tune_dir, tune_mag, state, retry_cnt,
           recoveries, outage_cycles, failed
  );

endinterface

// File: rtl/link_recovery_ctrl_cycle_timer.sv
// Loadable down-counter shared by all timed phases; it parks at zero, where
// expired stays high until the next load.
module cycle_timer
  import link_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (value_q != '0) begin
      value_d = value_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value   = value_q;
  assign expired = (value_q == '0);

endmodule

// File: rtl/link_recovery_ctrl.sv
// Link recovery sequencer: gates frame valid into the link monitor path and
// runs a bounded retune / settle / retrain / backoff loop on sustained link loss.
//
// state    | meaning
// IDLE     | controller parked, no frames
// MONITOR  | frames on, counting consecutive link-down cycles
// TUNE_REQ | tune step requested, held until ack
// SETTLE   | thermal settling after the tune step
// TRAIN    | frames on, waiting for link_up within the frame budget
// BACKOFF  | exponential wait before the next tune step
// FAILED   | retries exhausted, sticky until enable drops
module link_recovery_ctrl
  import link_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int TRAIN_FRAMES  = 32,
  parameter int BACKOFF_BASE  = 16,
  parameter int MAX_RETRIES   = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  link_recovery_ctrl_if.slave bus
);

  if (MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_retries
    $error("link_recovery_ctrl: MAX_RETRIES must be within 1..15");
  end
  if (BACKOFF_BASE < 1 || (longint'(BACKOFF_BASE) << 15) > longint'(32'hFFFF_FFFF)) begin : g_bad_backoff
    $error("link_recovery_ctrl: BACKOFF_BASE << 15 must fit in 32 bits");
  end
  if (SETTLE_CYCLES < 1 || TRAIN_FRAMES < 1) begin : g_bad_timing
    $error("link_recovery_ctrl: SETTLE_CYCLES and TRAIN_FRAMES must be at least 1");
  end

  localparam logic [TIMER_W-1:0] TRAIN_LOAD  = TIMER_W'(TRAIN_FRAMES - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BACKOFF_B   = TIMER_W'(BACKOFF_BASE);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  state_t              state_q, state_d;
  logic [RETRY_W-1:0]  retry_q, retry_d, retry_inc;
  logic [REC_W-1:0]    recov_q, recov_d;
  logic [OUTAGE_W-1:0] outage_q, outage_d;
  logic                abort_q, abort_d;
  logic                timer_load, timer_expired;
  logic [TIMER_W-1:0]  timer_val, timer_unused_value;

  cycle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .value    (timer_unused_value),
    .expired  (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    recov_d    = recov_q;
    outage_d   = outage_q;
    abort_d    = 1'b0;
    timer_load = 1'b0;
    timer_val  = TRAIN_LOAD;
    retry_inc  = retry_q + RETRY_W'(1);

    if (state_q inside {ST_TUNE_REQ, ST_SETTLE, ST_TRAIN, ST_BACKOFF, ST_FAILED} &&
        outage_q != '1) begin
      outage_d = outage_q + OUTAGE_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) begin
          state_d    = ST_MONITOR;
          timer_load = 1'b1;
        end
      end
      ST_MONITOR: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (bus.link_up) begin
          timer_load = 1'b1;
        end else if (timer_expired) begin
          state_d = ST_TUNE_REQ;
        end
      end
      ST_TUNE_REQ: begin
        // A disable seen at any point of the request is remembered until the ack.
        abort_d = abort_q | ~bus.enable;
        if (bus.tune_ack) begin
          abort_d = 1'b0;
          if (abort_q || !bus.enable) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_SETTLE;
            timer_load = 1'b1;
            timer_val  = SETTLE_LOAD;
          end
        end
      end
      ST_SETTLE: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d    = ST_TRAIN;
          timer_load = 1'b1;
        end
      end
      ST_TRAIN: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (bus.link_up) begin
          state_d    = ST_MONITOR;
          retry_d    = '0;
          timer_load = 1'b1;
          if (recov_q != '1) recov_d = recov_q + REC_W'(1);
        end else if (timer_expired) begin
          retry_d = retry_inc;
          if (retry_inc == RETRY_LIMIT) begin
            state_d = ST_FAILED;
          end else begin
            state_d    = ST_BACKOFF;
            timer_load = 1'b1;
            timer_val  = backoff_load(BACKOFF_B, retry_inc);
          end
        end
      end
      ST_BACKOFF: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (timer_expired) begin
          state_d = ST_TUNE_REQ;
        end
      end
      ST_FAILED: begin
        if (!bus.enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) retry_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      recov_q  <= '0;
      outage_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      recov_q  <= recov_d;
      outage_q <= outage_d;
      abort_q  <= abort_d;
    end
  end

  // Tune fields are only meaningful alongside the request and read zero otherwise.
  assign bus.frame_valid   = (state_q == ST_MONITOR) || (state_q == ST_TRAIN);
  assign bus.tune_req      = (state_q == ST_TUNE_REQ);
  assign bus.tune_dir      = (state_q == ST_TUNE_REQ) ? (retry_q[0] ? TUNE_COOL : TUNE_HEAT) : 1'b0;
  assign bus.tune_mag      = (state_q == ST_TUNE_REQ) ? MAG_W'(retry_inc) : '0;
  assign bus.state         = state_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.recoveries    = recov_q;
  assign bus.outage_cycles = outage_q;
  assign bus.failed        = (state_q == ST_FAILED);

endmodule

// File: tb/tb_link_recovery_ctrl.sv
// Bench for link_recovery_ctrl: scripted vector table, hand-written corner
// sequences and a randomized run against a cycle-level reference model.
module tb_link_recovery_ctrl;

  localparam int SC = 4;
  localparam int TF = 8;
  localparam int BB = 2;
  localparam int MR = 3;
  localparam longint OUT_MAX = 64'h0000_0000_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_pass   = 0;

  link_recovery_ctrl_if bus_if ();

  link_recovery_ctrl #(
    .SETTLE_CYCLES (SC),
    .TRAIN_FRAMES  (TF),
    .BACKOFF_BASE  (BB),
    .MAX_RETRIES   (MR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, elapsed counts and plain integer counters.
  typedef struct {
    int     st;
    int     lows;
    int     el;
    int     retry;
    int     rec;
    longint outage;
    bit     abort;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mstep(mdl_t s, bit en, bit lu, bit ack);
    mdl_t n = s;
    if (s.st >= 2 && s.outage < OUT_MAX) n.outage = s.outage + 1;
    case (s.st)
      0: if (en) begin n.st = 1; n.lows = 0; end
      1: if (!en) n.st = 0;
         else if (lu) n.lows = 0;
         else begin
           n.lows = s.lows + 1;
           if (n.lows == TF) n.st = 2;
         end
      2: begin
           n.abort = s.abort | !en;
           if (ack) begin
             n.st = n.abort ? 0 : 3;
             n.abort = 1'b0;
             n.el = 0;
           end
         end
      3: if (!en) n.st = 0;
         else begin
           n.el = s.el + 1;
           if (n.el == SC) begin n.st = 4; n.el = 0; end
         end
      4: if (!en) n.st = 0;
         else if (lu) begin
           n.st = 1; n.retry = 0; n.lows = 0;
           if (s.rec < 65535) n.rec = s.rec + 1;
         end else begin
           n.el = s.el + 1;
           if (n.el == TF) begin
             n.retry = s.retry + 1;
             n.el = 0;
             n.st = (n.retry == MR) ? 6 : 5;
           end
         end
      5: if (!en) n.st = 0;
         else begin
           n.el = s.el + 1;
           if (n.el == (BB << s.retry)) begin n.st = 2; n.el = 0; end
         end
      6: if (!en) n.st = 0;
      default: n.st = 0;
    endcase
    if (n.st == 0) begin n.retry = 0; n.abort = 1'b0; end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{default: 0};
    else        m <= mstep(m, bus_if.enable, bus_if.link_up, bus_if.tune_ack);
  end

  function automatic logic [63:0] mdl_vec(mdl_t s);
    logic       req = (s.st == 2);
    logic [3:0] r   = 4'(s.retry);
    return {1'b0, 3'(s.st), (s.st == 1) || (s.st == 4), req, req & r[0],
            req ? r + 4'd1 : 4'd0, r, 16'(s.rec), 32'(s.outage), s.st == 6};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {1'b0, bus_if.state, bus_if.frame_valid, bus_if.tune_req, bus_if.tune_dir,
            bus_if.tune_mag, bus_if.retry_cnt, bus_if.recoveries, bus_if.outage_cycles,
            bus_if.failed};
  endfunction

  typedef struct {
    bit         en, lu, ack;
    int         n;
    logic [2:0] st;
    bit         fv, req, dir;
    logic [3:0] mag, retry;
    logic [15:0] rec;
    bit         failed;
  } vec_t;

  function automatic vec_t mk(int en, int lu, int ack, int n, int st, int fv, int req,
                              int dir, int mag, int retry, int rec, int failed);
    vec_t v;
    v.en = 1'(en); v.lu = 1'(lu); v.ack = 1'(ack); v.n = n;
    v.st = 3'(st); v.fv = 1'(fv); v.req = 1'(req); v.dir = 1'(dir);
    v.mag = 4'(mag); v.retry = 4'(retry); v.rec = 16'(rec); v.failed = 1'(failed);
    return v;
  endfunction

  function automatic logic [63:0] exp_tbl(vec_t v);
    return 64'({v.st, v.fv, v.req, v.dir, v.mag, v.retry, v.rec, v.failed});
  endfunction

  function automatic logic [63:0] dut_tbl();
    return 64'({bus_if.state, bus_if.frame_valid, bus_if.tune_req, bus_if.tune_dir,
                bus_if.tune_mag, bus_if.retry_cnt, bus_if.recoveries, bus_if.failed});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic step(input int en, input int lu, input int ack, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.enable   = (en != 0);
      bus_if.link_up  = (lu != 0);
      bus_if.tune_ack = (ack != 0);
      @(posedge clk);
      @(negedge clk);
      chk("model", dut_vec(), mdl_vec(m));
    end
  endtask

  task automatic reset_dut();
    bus_if.enable   = 1'b0;
    bus_if.link_up  = 1'b0;
    bus_if.tune_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", dut_vec(), 64'd0);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    // en lu ack n | state fv req dir mag retry rec failed
    tbl.push_back(mk(1,1,0,1,   1,1,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,100, 1,1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,7,   1,1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,   2,0,1,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,2,   2,0,1,0,1,0,0,0));
    tbl.push_back(mk(1,0,1,1,   3,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,3,   3,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,   4,1,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,4,   4,1,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,1,   1,1,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,8,   2,0,1,0,1,0,1,0));
    tbl.push_back(mk(1,0,1,1,   3,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,4,   4,1,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,7,   4,1,0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,1,   5,0,0,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,3,   5,0,0,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,1,   2,0,1,1,2,1,1,0));
    tbl.push_back(mk(1,0,1,1,   3,0,0,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,4,   4,1,0,0,0,1,1,0));
    tbl.push_back(mk(1,0,0,8,   5,0,0,0,0,2,1,0));
    tbl.push_back(mk(1,0,0,7,   5,0,0,0,0,2,1,0));
    tbl.push_back(mk(1,0,0,1,   2,0,1,0,3,2,1,0));
    tbl.push_back(mk(1,0,1,1,   3,0,0,0,0,2,1,0));
    tbl.push_back(mk(1,0,0,4,   4,1,0,0,0,2,1,0));
    tbl.push_back(mk(1,0,0,8,   6,0,0,0,0,3,1,1));
    tbl.push_back(mk(0,0,0,1,   0,0,0,0,0,0,1,0));

    #1;
    reset_dut();

    // Bring-up, drop/recover, retry exhaustion and exit from FAILED.
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].lu, tbl[i].ack, tbl[i].n);
      chk($sformatf("vec%0d", i), dut_tbl(), exp_tbl(tbl[i]));
    end

    // Enable dropped while a tune request is outstanding.
    reset_dut();
    step(1, 1, 0, 1);
    step(1, 0, 0, 8);
    chk("s4_in_req", 64'({bus_if.state, bus_if.tune_req}), 64'd5);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      chk($sformatf("s4_req_held%0d", i), 64'({bus_if.state, bus_if.tune_req}), 64'd5);
    end
    step(0, 0, 1, 1);
    chk("s4_to_idle", 64'({bus_if.state, bus_if.tune_req, bus_if.retry_cnt}), 64'd0);

    // Link comes up exactly on the final training frame.
    reset_dut();
    step(1, 1, 0, 1);
    step(1, 0, 0, 8);
    step(1, 0, 1, 1);
    step(1, 0, 0, 4);
    step(1, 0, 0, 7);
    chk("s6_still_train", 64'(bus_if.state), 64'd4);
    step(1, 1, 0, 1);
    chk("s6_last_frame", 64'({bus_if.state, bus_if.recoveries, bus_if.retry_cnt}),
        64'({3'd1, 16'd1, 4'd0}));
    step(1, 1, 0, 1);
    chk("s6_no_backoff", 64'(bus_if.state), 64'd1);

    // Asynchronous reset in the middle of a backoff.
    reset_dut();
    step(1, 1, 0, 1);
    step(1, 0, 0, 8);
    step(1, 0, 1, 1);
    step(1, 0, 0, 4);
    step(1, 0, 0, 8);
    step(1, 0, 0, 1);
    chk("s5_in_backoff", 64'({bus_if.state, bus_if.retry_cnt}), 64'({3'd5, 4'd1}));
    #2 rst_n = 1'b0;
    #1 chk("s5_async_reset", dut_vec(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    reset_dut();
    begin
      int lu_r  = 1;
      int en_r  = 1;
      int ack_r = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 23) == 0) lu_r = ($urandom_range(0, 9) < 4) ? 1 : 0;
        en_r  = ($urandom_range(0, 149) != 0) ? 1 : 0;
        ack_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
        step(en_r, lu_r, ack_r, 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/link_recovery_ctrl.md
# link_recovery_ctrl

Link recovery sequencer for the co-simulation top. It gates the frame `valid` stream into the CRC-sampling/link-monitor path and watches the resulting `link_up`. On sustained link loss it runs a bounded retune-and-retrain loop: it requests heater/tuning steps from the plant over a req/ack handshake, waits for thermal settling, retrains with frames, and backs off exponentially between attempts. It sits between the cocotb plant interface and the existing link monitoring path.

## Interface

**Parameters**

- `SETTLE_CYCLES`, default 64: idle cycles after each tune ack, before retraining.
- `TRAIN_FRAMES`, default 32: frame budget per training attempt. It is also the consecutive link-down cycles tolerated in MONITOR.
- `BACKOFF_BASE`, default 16: base backoff in cycles; attempt n waits `BACKOFF_BASE << n`.
- `MAX_RETRIES`, default 4: failed attempts before FAILED. Legal range 1..15.

**Ports**

- `clk  in  1`: single clock.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `enable  in  1`: run controller; 0 requests return to IDLE.
- `link_up  in  1`: link state from the link monitor.
- `tune_ack  in  1`: plant accepted the tune step.
- `frame_valid  out  1`: drives the monitor path's `valid`.
- `tune_req  out  1`: tune step request.
- `tune_dir  out  1`: step direction; equals `retry_cnt[0]` (0 = heat, 1 = cool).
- `tune_mag  out  4`: step magnitude; equals `retry_cnt + 1`.
- `state  out  3`: current FSM state encoding (debug).
- `retry_cnt  out  4`: attempts used in the current outage.
- `recoveries  out  16`: successful recoveries; saturating.
- `outage_cycles  out  32`: cycles spent outside IDLE/MONITOR; saturating.
- `failed  out  1`: sticky give-up flag.

## Operation

**Reset values.** State is IDLE; every output and counter is 0.

**States and transitions**

- **IDLE (0):** `frame_valid = 0`. Moves to MONITOR when `enable = 1`.
- **MONITOR (1):** `frame_valid = 1`. A down-counter tracks consecutive `link_up = 0` cycles and reloads on `link_up = 1`. When the count reaches `TRAIN_FRAMES`, go to TUNE_REQ. This path covers both initial bring-up failure and a later drop.
- **TUNE_REQ (2):** `tune_req = 1` and `frame_valid = 0`. `tune_req` is held until `tune_ack` is sampled high, then the FSM goes to SETTLE.
- **SETTLE (3):** counts `SETTLE_CYCLES`, then goes to TRAIN.
- **TRAIN (4):** `frame_valid = 1`.
  - `link_up = 1` within `TRAIN_FRAMES` cycles: go to MONITOR, clear `retry_cnt`, increment `recoveries`.
  - Budget expires: increment `retry_cnt`. If the new value equals `MAX_RETRIES`, go to FAILED; otherwise go to BACKOFF.
- **BACKOFF (5):** waits `BACKOFF_BASE << retry_cnt` cycles, then goes to TUNE_REQ.
- **FAILED (6):** `failed = 1` and `frame_valid = 0`. Exits only when `enable = 0`; exit goes to IDLE and clears `failed` and `retry_cnt`.

**Boundary conditions**

- **Enable dropped:** `enable = 0` in any state sends the FSM to IDLE on the next edge, except TUNE_REQ. In TUNE_REQ, `tune_req` stays high until ack; the FSM then goes to IDLE, not SETTLE, so no request is ever abandoned.
- **Ack with request:** `tune_ack` high in the same cycle `tune_req` first rises counts as an ack. `tune_ack` outside TUNE_REQ is ignored.
- **Link up on last training frame:** `link_up = 1` in the final TRAIN cycle is a success; success has priority over budget expiry.
- **Retry counter:** `retry_cnt` persists across BACKOFF and is cleared only on success, on entry to IDLE, or by reset.
- **Backoff width:** the backoff value is computed in 32 bits. `BACKOFF_BASE << 15` must fit; this is a parameter assertion.
- **Saturation:** counters saturate at all-ones and never wrap.
- **Reset mid-operation:** asynchronous assert forces IDLE and all-zero outputs immediately; `tune_req` drops without waiting for ack.

## Timing

- Moore outputs. `frame_valid`, `tune_req`, `tune_dir`, `tune_mag`, `state` and `failed` decode from the registered state and `retry_cnt` only. They change on the same edge as the state and never combinationally from inputs.
- `enable` sampled at edge N gives `frame_valid = 1` after edge N.
- `tune_ack` sampled at edge N drops `tune_req` after edge N, and SETTLE starts at edge N.
- Worst-case loss-to-first-request latency: `TRAIN_FRAMES` cycles after `link_up` falls, plus 1.
- `outage_cycles` increments on every edge where the state is TUNE_REQ, SETTLE, TRAIN, BACKOFF or FAILED.

## Structure

- **Shared package `link_ctrl_pkg`:** the `state_t` enum (3-bit, encodings as listed under Operation), the tune direction constants, and the counter width localparams.
- **Sub-module `cycle_timer`:** a loadable 32-bit down-counter with `load`, `value` and `expired` ports. It is instantiated once and shared by the MONITOR, SETTLE, TRAIN and BACKOFF counts, which never overlap.

## Test plan

All scenarios use `SETTLE_CYCLES=4`, `TRAIN_FRAMES=8`, `BACKOFF_BASE=2`, `MAX_RETRIES=3`.

1. **Reset and enable:** hold reset, then enable with `link_up = 1` -> all outputs 0 after reset; `frame_valid = 1` one edge after enable; state stays MONITOR for 100 cycles.
2. **Drop and recover:** drop `link_up` for 8 cycles -> `tune_req` rises. Ack 3 cycles later -> 4 SETTLE cycles, then TRAIN. Raise `link_up` on TRAIN cycle 5 -> MONITOR, `recoveries = 1`, `retry_cnt = 0`.
3. **Exhaust retries:** keep `link_up = 0` throughout -> backoffs of 4 then 8 cycles; `tune_mag` sequence 1, 2, 3; `tune_dir` sequence 0, 1, 0; `failed = 1` after the third TRAIN. Deassert enable -> IDLE with `failed = 0`.
4. **Enable dropped during TUNE_REQ:** deassert enable while `tune_req = 1`, ack 5 cycles later -> `tune_req` held all 5 cycles, then IDLE; SETTLE is never entered.
5. **Reset mid-BACKOFF:** assert `rst_n = 0` asynchronously during BACKOFF -> state IDLE and all outputs 0 immediately, before the next edge.
6. **Success on last frame:** raise `link_up` exactly on the 8th TRAIN cycle -> MONITOR and `recoveries` increments; no BACKOFF entry.
